// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches 1- or 2-byte instructions from a shared memory
// and computes the address the external pc register loads on every clock edge.
module pc_sequencer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] current_address,
  output logic [ADDR_WIDTH-1:0] next_address,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  input  logic [ADDR_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  input  logic                  zero_flag,
  output logic [ADDR_WIDTH-1:0] ir,
  output logic                  halted,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_OPERAND = 2'd1,
    S_HALTED  = 2'd2
  } state_t;

  localparam logic [1:0] CLS_ALU  = 2'd0;
  localparam logic [1:0] CLS_JMP  = 2'd1;
  localparam logic [1:0] CLS_BZ   = 2'd2;
  localparam logic [1:0] CLS_HALT = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   ir_q;
  logic                    halted_q;
  logic [1:0]              data_cls;
  logic [1:0]              ir_cls;
  logic [ADDR_WIDTH-1:0]   addr_inc;

  assign data_cls = mem_data[ADDR_WIDTH-1 -: 2];
  assign ir_cls   = ir_q[ADDR_WIDTH-1 -: 2];
  assign addr_inc = current_address + ONE;  // wraps at the top of the address space

  assign mem_addr = current_address;
  assign ir       = ir_q;
  assign halted   = halted_q;
  assign state_o  = state_q;

  // Memory handshake: mem_read is the request; a read completes on the posedge where
  // mem_read and mem_ready are both 1. mem_data is ignored in any other cycle, so a
  // stall simply holds the address and state.
  always_comb begin
    next_address = current_address;
    mem_read     = 1'b0;
    if (reset) begin
      next_address = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready && data_cls != CLS_HALT) next_address = addr_inc;
        end
        S_OPERAND: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            if (ir_cls == CLS_JMP || (ir_cls == CLS_BZ && zero_flag)) next_address = mem_data;
            else next_address = addr_inc;
          end
        end
        default: next_address = current_address;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            ir_q <= mem_data;
            case (data_cls)
              CLS_ALU: state_q <= S_FETCH;
              CLS_HALT: begin
                state_q  <= S_HALTED;
                halted_q <= 1'b1;
              end
              default: state_q <= S_OPERAND;
            endcase
          end
        end
        S_OPERAND: begin
          // ir keeps the opcode; the operand byte only steers next_address.
          if (mem_ready) state_q <= S_FETCH;
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: an instruction-level model predicts every completed memory
// read; a negedge monitor pops and compares as reads happen.
module tb_pc_sequencer;
  localparam int W    = 8;
  localparam int SB_W = W + 1;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] current_address;
  logic [W-1:0] next_address;
  logic [W-1:0] mem_addr;
  logic         mem_read;
  logic [W-1:0] mem_data;
  logic         mem_ready;
  logic         zero_flag;
  logic [W-1:0] ir;
  logic         halted;
  logic [1:0]   state_o;

  always #5 clock = ~clock;

  pc_sequencer #(.ADDR_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .current_address(current_address),
    .next_address(next_address), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_data(mem_data), .mem_ready(mem_ready), .zero_flag(zero_flag),
    .ir(ir), .halted(halted), .state_o(state_o)
  );

  // External pc register
  always @(posedge clock) current_address <= next_address;

  logic [W-1:0]    mem [256];
  bit              zmap [256];
  logic [SB_W-1:0] exp_q [$];  // {is_opcode, address} of each expected completed read
  logic [SB_W-1:0] sb_e;
  logic [W-1:0]    opc_addr;
  int              tests = 0;
  int              fails = 0;
  bit              run_active = 1'b0;
  bit              ir_pend = 1'b0;
  logic [W-1:0]    ir_exp;
  bit              model_halts;
  logic [W-1:0]    halt_addr;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level interpreter of the memory image starting at address 0.
  function automatic void build_trace(input int cap);
    logic [W-1:0] pc = '0;
    logic [W-1:0] op;
    logic [W-1:0] opnd_addr;
    exp_q.delete();
    model_halts = 1'b0;
    halt_addr   = '0;
    while (exp_q.size() < cap) begin
      op = mem[pc];
      exp_q.push_back({1'b1, pc});
      if (op[7:6] == 2'b11) begin
        model_halts = 1'b1;
        halt_addr   = pc;
        break;
      end
      if (op[7:6] == 2'b00) begin
        pc = pc + 8'd1;
      end else begin
        opnd_addr = pc + 8'd1;
        exp_q.push_back({1'b0, opnd_addr});
        if (op[7:6] == 2'b01 || zmap[opnd_addr]) pc = mem[opnd_addr];
        else pc = opnd_addr + 8'd1;
      end
    end
  endfunction

  always @(negedge clock) begin
    if (run_active) begin
      if (ir_pend) begin
        check("ir_after_fetch", ir, ir_exp);
        ir_pend = 1'b0;
      end
      if (!reset) begin
        check("mem_addr", mem_addr, current_address);
        if (halted) begin
          check("halt_mem_read", W'(mem_read), '0);
          check("halt_hold", next_address, current_address);
        end else if (mem_ready) begin
          check("read_req", W'(mem_read), W'(1));
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: read at 0x%0h, expected no further read", mem_addr);
          end else begin
            sb_e = exp_q.pop_front();
            check("read_addr", current_address, sb_e[W-1:0]);
            if (sb_e[W]) begin
              ir_pend = 1'b1;
              ir_exp  = mem[sb_e[W-1:0]];
            end else begin
              opc_addr = sb_e[W-1:0] - 8'd1;
              check("ir_hold_operand", ir, mem[opc_addr]);
            end
          end
        end else begin
          check("stall_read", W'(mem_read), W'(1));
          check("stall_hold", next_address, current_address);
        end
      end
    end
  end

  task automatic drive_inputs(input int stall_pct);
    if (int'($urandom_range(0, 99)) < stall_pct) begin
      mem_ready = 1'b0;
      mem_data  = W'($urandom);
      zero_flag = 1'($urandom_range(0, 1));
    end else begin
      mem_ready = 1'b1;
      mem_data  = mem[current_address];
      zero_flag = zmap[current_address];
    end
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_data  = 8'hFF;
    zero_flag = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("rst_next_address", next_address, '0);
      check("rst_mem_read", W'(mem_read), '0);
      @(posedge clock);
      #1;
    end
    check("rst_halted", W'(halted), '0);
    check("rst_ir", ir, '0);
    check("rst_state", W'(state_o), '0);
    check("rst_pc", current_address, '0);
    reset = 1'b0;
  endtask

  task automatic run_program(input int cap, input int stall_pct);
    int cyc  = 0;
    int post = 0;
    build_trace(cap);
    reset_dut();
    ir_pend    = 1'b0;
    run_active = 1'b1;
    while (cyc < 2000) begin
      if (exp_q.size() == 0) begin
        if (!model_halts) begin
          mem_ready = 1'b0;
          @(posedge clock);
          #1;
          break;
        end
        post++;
        if (post > 4) break;
      end
      drive_inputs(stall_pct);
      @(posedge clock);
      #1;
      cyc++;
    end
    if (cyc >= 2000) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: %0d reads outstanding, expected 0", exp_q.size());
    end
    if (model_halts) begin
      check("halted_flag", W'(halted), W'(1));
      check("halt_pc", current_address, halt_addr);
    end
    run_active = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'hC0;
      zmap[i] = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    mem_data  = '0;
    zero_flag = 1'b0;

    // ALU, ALU, JMP 0x20, BZ 0x40 taken, then the same program with BZ not taken
    clear_mem();
    mem[8'h00] = 8'h05;
    mem[8'h01] = 8'h07;
    mem[8'h02] = 8'h40;
    mem[8'h03] = 8'h20;
    mem[8'h20] = 8'h80;
    mem[8'h21] = 8'h40;
    zmap[8'h21] = 1'b1;
    run_program(64, 0);
    zmap[8'h21] = 1'b0;
    run_program(64, 40);

    // JMP at 0xFF takes its operand from 0x00, lands on HALT at 0x10
    clear_mem();
    mem[8'h00] = 8'h10;
    mem[8'h01] = 8'h40;
    mem[8'h02] = 8'hFF;
    mem[8'hFF] = 8'h40;
    mem[8'h10] = 8'hC0;
    run_program(64, 40);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]  = W'($urandom);
        zmap[i] = 1'($urandom_range(0, 1));
      end
      run_program(40, int'($urandom_range(0, 50)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
